// File: rtl/shield_pinmux.sv
// Shield header pin multiplexer: per-pin function select with a break/settle reconfiguration FSM.
// Optional build macro SHIELD_PINMUX_LOOPBACK_EN adds a LOOPBACK input that turns pads around internally.
module shield_pinmux #(
    parameter int                  NUM_PINS      = 16,
    parameter int                  NUM_FUNCS     = 4,
    parameter int                  BREAK_CYCLES  = 2,
    parameter int                  SETTLE_CYCLES = 2,
    parameter logic [NUM_PINS-1:0] IDLE_LEVEL    = 16'hC000,
    parameter int                  PIN_W         = 4,
    parameter int                  FUNC_W        = 2
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
`ifdef SHIELD_PINMUX_LOOPBACK_EN
    input  logic                          LOOPBACK,
`endif
    input  logic                          CFG_VALID,
    output logic                          CFG_READY,
    input  logic [PIN_W-1:0]              CFG_PIN,
    input  logic [FUNC_W-1:0]             CFG_FUNC,
    output logic                          CFG_ERR,
    output logic                          BUSY,
    output logic [NUM_PINS*FUNC_W-1:0]    CUR_FUNC,
    input  logic [NUM_FUNCS*NUM_PINS-1:0] FUNC_OUT,
    input  logic [NUM_FUNCS*NUM_PINS-1:0] FUNC_OE,
    output logic [NUM_FUNCS*NUM_PINS-1:0] FUNC_IN,
    input  logic [NUM_PINS-1:0]           PAD_IN,
    output logic [NUM_PINS-1:0]           PAD_OUT,
    output logic [NUM_PINS-1:0]           PAD_OE
);

    localparam int MAX_CYC = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_SETTLE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PIN_W-1:0]    pin_q, pin_d;
    logic [FUNC_W-1:0]   func_q, func_d;
    logic                err_q, err_d;
    logic [FUNC_W-1:0]   cur_func_q [NUM_PINS];
    logic [FUNC_W-1:0]   cur_func_d [NUM_PINS];
    logic [NUM_PINS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    logic                req_ok, req_same, commit;
    logic [FUNC_W-1:0]   req_cur;
    logic                in_break, in_settle;
    logic                oe_kill;
    logic [NUM_PINS-1:0] sync_src;

`ifdef SHIELD_PINMUX_LOOPBACK_EN
    assign oe_kill  = HRESET | LOOPBACK;
    assign sync_src = LOOPBACK ? PAD_OUT : PAD_IN;
`else
    assign oe_kill  = HRESET;
    assign sync_src = PAD_IN;
`endif

    // Request decode; CFG_PIN may be wider than the pin range, so look up by comparison.
    always_comb begin
        req_cur = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (32'(CFG_PIN) == p) req_cur = cur_func_q[p];
        end
        req_ok   = (32'(CFG_PIN) < NUM_PINS) && (32'(CFG_FUNC) < NUM_FUNCS);
        req_same = (CFG_FUNC == req_cur);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pin_q   <= '0;
            func_q  <= '0;
            err_q   <= 1'b0;
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            for (int p = 0; p < NUM_PINS; p++) cur_func_q[p] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pin_q   <= pin_d;
            func_q  <= func_d;
            err_q   <= err_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            for (int p = 0; p < NUM_PINS; p++) cur_func_q[p] <= cur_func_d[p];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pin_d   = pin_q;
        func_d  = func_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (CFG_VALID) begin
                    if (!req_ok) begin
                        err_d = 1'b1;
                    end else if (!req_same) begin
                        pin_d   = CFG_PIN;
                        func_d  = CFG_FUNC;
                        cnt_d   = CNT_W'(BREAK_CYCLES - 1);
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        CFG_READY = (state_q == ST_IDLE);
        BUSY      = !CFG_READY;
        CFG_ERR   = err_q;
        in_break  = (state_q == ST_BREAK);
        in_settle = (state_q == ST_SETTLE);
        commit    = in_break && (cnt_q == '0);
    end

    always_comb begin
        sync1_d = sync_src;
        sync2_d = sync1_q;
        for (int p = 0; p < NUM_PINS; p++) begin
            cur_func_d[p] = (commit && (32'(pin_q) == p)) ? func_q : cur_func_q[p];
        end
    end

    genvar gi, fi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            logic mux_out, mux_oe, is_target;

            assign is_target = (32'(pin_q) == gi);

            always_comb begin
                mux_out = 1'b0;
                mux_oe  = 1'b0;
                for (int f = 0; f < NUM_FUNCS; f++) begin
                    if (cur_func_q[gi] == FUNC_W'(f)) begin
                        mux_out = FUNC_OUT[f*NUM_PINS + gi];
                        mux_oe  = FUNC_OE[f*NUM_PINS + gi];
                    end
                end
            end

            assign PAD_OUT[gi]                     = mux_out;
            assign PAD_OE[gi]                      = mux_oe & ~(in_break & is_target) & ~oe_kill;
            assign CUR_FUNC[gi*FUNC_W +: FUNC_W]   = cur_func_q[gi];

            // Unselected functions, and every function while the pin settles, see the idle level.
            for (fi = 0; fi < NUM_FUNCS; fi++) begin : g_func
                assign FUNC_IN[fi*NUM_PINS + gi] =
                    ((cur_func_q[gi] == FUNC_W'(fi)) && !(in_settle && is_target))
                        ? sync2_q[gi] : IDLE_LEVEL[gi];
            end
        end
    endgenerate

endmodule

// File: tb/tb_shield_pinmux.sv
// Directed testbench for shield_pinmux; PIN_W/FUNC_W are widened so out-of-range requests can be driven.
`timescale 1ns/1ps
module tb_shield_pinmux;

    localparam int NP = 16;
    localparam int NF = 4;
    localparam int PW = 5;
    localparam int FW = 3;

    logic             HCLK = 1'b0;
    logic             HRESET;
`ifdef SHIELD_PINMUX_LOOPBACK_EN
    logic             LOOPBACK;
`endif
    logic             CFG_VALID;
    logic             CFG_READY;
    logic [PW-1:0]    CFG_PIN;
    logic [FW-1:0]    CFG_FUNC;
    logic             CFG_ERR;
    logic             BUSY;
    logic [NP*FW-1:0] CUR_FUNC;
    logic [NF*NP-1:0] FUNC_OUT;
    logic [NF*NP-1:0] FUNC_OE;
    logic [NF*NP-1:0] FUNC_IN;
    logic [NP-1:0]    PAD_IN;
    logic [NP-1:0]    PAD_OUT;
    logic [NP-1:0]    PAD_OE;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [NP*FW-1:0] exp_cur;

    always #5 HCLK = ~HCLK;

    shield_pinmux #(
        .NUM_PINS(NP), .NUM_FUNCS(NF), .BREAK_CYCLES(2), .SETTLE_CYCLES(2),
        .IDLE_LEVEL(16'hC000), .PIN_W(PW), .FUNC_W(FW)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
`ifdef SHIELD_PINMUX_LOOPBACK_EN
        .LOOPBACK(LOOPBACK),
`endif
        .CFG_VALID(CFG_VALID),
        .CFG_READY(CFG_READY),
        .CFG_PIN(CFG_PIN),
        .CFG_FUNC(CFG_FUNC),
        .CFG_ERR(CFG_ERR),
        .BUSY(BUSY),
        .CUR_FUNC(CUR_FUNC),
        .FUNC_OUT(FUNC_OUT),
        .FUNC_OE(FUNC_OE),
        .FUNC_IN(FUNC_IN),
        .PAD_IN(PAD_IN),
        .PAD_OUT(PAD_OUT),
        .PAD_OE(PAD_OE)
    );

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else begin
            pass_cnt++;
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick(); tick();
        chk("rst_pad_oe", 64'(PAD_OE), 64'h0);
        chk("rst_cur_func", 64'(CUR_FUNC), 64'h0);
        chk("rst_ready_busy_err", 64'({CFG_READY, BUSY, CFG_ERR}), 64'b100);
        chk("rst_func_in0", 64'(FUNC_IN[15:0]), 64'hC000);
        HRESET = 1'b0;
        #1;
        chk("rst_release_pad_oe", 64'(PAD_OE), 64'hFFFF);
        tick();
        chk("rst_sync_1cyc", 64'(FUNC_IN[15:0]), 64'hC000);
        tick();
        chk("rst_sync_2cyc", 64'(FUNC_IN[15:0]), 64'h0000);
        exp_cur = '0;
    endtask

    task automatic test_reconfig();
        CFG_PIN = 5'd14; CFG_FUNC = 3'd2; CFG_VALID = 1'b1;
        #1;
        chk("cfg_pre_oe14", 64'(PAD_OE[14]), 64'h1);
        tick();
        CFG_VALID = 1'b0;
        chk("cfg_b1_busy", 64'({CFG_READY, BUSY}), 64'b01);
        chk("cfg_b1_oe", 64'(PAD_OE), 64'hBFFF);
        chk("cfg_b1_cur", 64'(CUR_FUNC), 64'(exp_cur));
        tick();
        chk("cfg_b2_oe14", 64'(PAD_OE[14]), 64'h0);
        chk("cfg_b2_cur", 64'(CUR_FUNC), 64'(exp_cur));
        exp_cur[14*FW +: FW] = 3'd2;
        tick();
        chk("cfg_s1_cur", 64'(CUR_FUNC), 64'(exp_cur));
        chk("cfg_s1_oe14", 64'(PAD_OE[14]), 64'h1);
        chk("cfg_s1_out14", 64'(PAD_OUT[14]), 64'h1);
        chk("cfg_s1_fin2_14", 64'(FUNC_IN[2*NP+14]), 64'h1);
        tick();
        chk("cfg_s2_fin2_14", 64'(FUNC_IN[2*NP+14]), 64'h1);
        chk("cfg_s2_busy", 64'(BUSY), 64'h1);
        tick();
        chk("cfg_done_ready", 64'({CFG_READY, BUSY}), 64'b10);
        chk("cfg_done_fin2_14", 64'(FUNC_IN[2*NP+14]), 64'h0);
        chk("cfg_done_fin0_14", 64'(FUNC_IN[14]), 64'h1);
    endtask

    task automatic test_errors();
        CFG_PIN = 5'd16; CFG_FUNC = 3'd1; CFG_VALID = 1'b1;
        tick();
        CFG_VALID = 1'b0;
        chk("err_pin_pulse", 64'({CFG_ERR, CFG_READY, BUSY}), 64'b110);
        tick();
        chk("err_pin_clear", 64'(CFG_ERR), 64'h0);
        CFG_PIN = 5'd2; CFG_FUNC = 3'd5; CFG_VALID = 1'b1;
        tick();
        CFG_VALID = 1'b0;
        chk("err_func5_pulse", 64'({CFG_ERR, CFG_READY, BUSY}), 64'b110);
        CFG_PIN = 5'd2; CFG_FUNC = 3'd4; CFG_VALID = 1'b1;
        tick();
        CFG_VALID = 1'b0;
        chk("err_func4_pulse", 64'(CFG_ERR), 64'h1);
        tick();
        chk("err_no_change", 64'(CUR_FUNC), 64'(exp_cur));
        chk("err_clear", 64'({CFG_ERR, CFG_READY}), 64'b01);
    endtask

    task automatic test_noop();
        CFG_PIN = 5'd3; CFG_FUNC = 3'd0; CFG_VALID = 1'b1;
        tick();
        CFG_VALID = 1'b0;
        chk("noop_busy_err", 64'({BUSY, CFG_ERR, CFG_READY}), 64'b001);
        chk("noop_oe", 64'(PAD_OE), 64'hFFFF);
        chk("noop_cur", 64'(CUR_FUNC), 64'(exp_cur));
    endtask

    task automatic test_back_to_back();
        CFG_PIN = 5'd5; CFG_FUNC = 3'd1; CFG_VALID = 1'b1;
        tick();
        CFG_FUNC = 3'd3;
        chk("b2b_a_busy", 64'(BUSY), 64'h1);
        tick(); tick(); tick();
        exp_cur[5*FW +: FW] = 3'd1;
        chk("b2b_a_ignored_busy", 64'(CUR_FUNC), 64'(exp_cur));
        tick();
        chk("b2b_a_ready", 64'(CFG_READY), 64'h1);
        tick();
        CFG_VALID = 1'b0;
        chk("b2b_b_started", 64'({BUSY, PAD_OE[5]}), 64'b10);
        tick(); tick();
        exp_cur[5*FW +: FW] = 3'd3;
        chk("b2b_b_commit", 64'(CUR_FUNC), 64'(exp_cur));
        tick(); tick();
        chk("b2b_b_ready", 64'({CFG_READY, BUSY}), 64'b10);
    endtask

    task automatic test_reset_mid();
        CFG_PIN = 5'd11; CFG_FUNC = 3'd1; CFG_VALID = 1'b1;
        tick();
        CFG_VALID = 1'b0;
        chk("mid_break_oe11", 64'({BUSY, PAD_OE[11]}), 64'b10);
        HRESET = 1'b1;
        #1;
        chk("mid_rst_oe", 64'(PAD_OE), 64'h0);
        tick();
        exp_cur = '0;
        chk("mid_rst_cur", 64'(CUR_FUNC), 64'(exp_cur));
        chk("mid_rst_ready", 64'({CFG_READY, BUSY}), 64'b10);
        HRESET = 1'b0;
        tick(); tick();
        chk("mid_after_cur11", 64'(CUR_FUNC[11*FW +: FW]), 64'h0);
    endtask

`ifdef SHIELD_PINMUX_LOOPBACK_EN
    task automatic test_loopback();
        FUNC_OUT[15:0] = 16'h00A5;
        LOOPBACK = 1'b1;
        #1;
        chk("lb_oe", 64'(PAD_OE), 64'h0);
        tick();
        chk("lb_1cyc", 64'(FUNC_IN[15:0]), 64'h0000);
        tick();
        chk("lb_2cyc", 64'(FUNC_IN[15:0]), 64'h00A5);
        LOOPBACK = 1'b0;
        tick();
    endtask
`endif

    initial begin
        HRESET    = 1'b1;
`ifdef SHIELD_PINMUX_LOOPBACK_EN
        LOOPBACK  = 1'b0;
`endif
        CFG_VALID = 1'b0;
        CFG_PIN   = '0;
        CFG_FUNC  = '0;
        PAD_IN    = 16'h0000;
        FUNC_OUT  = '0;
        FUNC_OE   = '0;
        FUNC_OUT[15:0]     = 16'h1234;
        FUNC_OE[15:0]      = 16'hFFFF;
        FUNC_OUT[2*NP+14]  = 1'b1;
        FUNC_OE[2*NP+14]   = 1'b1;
        exp_cur = '0;

        test_reset();
        test_reconfig();
        test_errors();
        test_noop();
        test_back_to_back();
        test_reset_mid();
`ifdef SHIELD_PINMUX_LOOPBACK_EN
        test_loopback();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
